pmc_pm_sequencer: RTL and testbench

- Command-driven sequencer owning the master side of the pixel-matrix control bundle: res[9:0], store, strobe, gate, sh_a, sh_b, clk_sh.
- Accepts one command at a time from the PMC core or register file.
- Generates exact cycle-timed waveforms for acquisition (gate→strobe→store), pixel-register shifting (sh_a/sh_b + clk_sh pulses) and pixel reset (res pulse).

---
 rtl/pmc_pm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pmc_pm_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmc_pm_sequencer.sv
// Pixel-matrix control sequencer: runs one ACQUIRE / SHIFT_A / SHIFT_B / RESET command
// at a time with cycle-exact registered waveforms. Optional abort input: PMC_SEQ_ABORT_EN.
module pmc_pm_sequencer #(
    parameter int CLK_DIV       = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [9:0]       cmd_res,
`ifdef PMC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [9:0]       res,
    output logic             store,
    output logic             strobe,
    output logic             gate,
    output logic             sh_a,
    output logic             sh_b,
    output logic             clk_sh
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GATE     = 3'd1;
    localparam logic [2:0] ST_STROBE   = 3'd2;
    localparam logic [2:0] ST_STORE    = 3'd3;
    localparam logic [2:0] ST_SHIFT_HI = 3'd4;
    localparam logic [2:0] ST_SHIFT_LO = 3'd5;
    localparam logic [2:0] ST_RESET    = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [1:0] OP_ACQUIRE = 2'd0;
    localparam logic [1:0] OP_SHIFT_A = 2'd1;
    localparam logic [1:0] OP_SHIFT_B = 2'd2;
    localparam logic [1:0] OP_RESET   = 2'd3;

    localparam logic [7:0]       CLK_DIV_LD = 8'(CLK_DIV - 1);
    localparam logic [7:0]       STROBE_LD  = 8'(STROBE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

    logic [2:0]       state, state_nxt;
    logic [LEN_W-1:0] len_cnt, len_cnt_nxt;
    logic [7:0]       phase_cnt, phase_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [9:0]       res_q, res_nxt;
    logic [LEN_W-1:0] len_ld;
    logic             in_busy_state;
    logic             abort_hit;

    // Counters hold "cycles remaining minus one", so a zero length behaves as one.
    assign len_ld        = (cmd_len == '0) ? '0 : cmd_len - LEN_ONE;
    assign in_busy_state = (state != ST_IDLE) && (state != ST_DONE);

`ifdef PMC_SEQ_ABORT_EN
    assign abort_hit = abort && in_busy_state;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_nxt   = state;
        len_cnt_nxt = len_cnt;
        phase_nxt   = phase_cnt;
        op_nxt      = op_q;
        res_nxt     = res_q;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_nxt      = cmd_op;
                    res_nxt     = cmd_res;
                    len_cnt_nxt = len_ld;
                    phase_nxt   = CLK_DIV_LD;
                    case (cmd_op)
                        OP_ACQUIRE: state_nxt = ST_GATE;
                        OP_SHIFT_A,
                        OP_SHIFT_B: state_nxt = ST_SHIFT_HI;
                        default:    state_nxt = ST_RESET;
                    endcase
                end
            end
            ST_GATE: begin
                if (len_cnt == '0) begin
                    state_nxt = ST_STROBE;
                    phase_nxt = STROBE_LD;
                end else begin
                    len_cnt_nxt = len_cnt - LEN_ONE;
                end
            end
            ST_STROBE: begin
                if (phase_cnt == 8'd0) state_nxt = ST_STORE;
                else                   phase_nxt = phase_cnt - 8'd1;
            end
            ST_STORE: state_nxt = ST_DONE;
            ST_SHIFT_HI: begin
                if (phase_cnt == 8'd0) begin
                    state_nxt = ST_SHIFT_LO;
                    phase_nxt = CLK_DIV_LD;
                end else begin
                    phase_nxt = phase_cnt - 8'd1;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_cnt != 8'd0) begin
                    phase_nxt = phase_cnt - 8'd1;
                end else if (len_cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt   = ST_SHIFT_HI;
                    phase_nxt   = CLK_DIV_LD;
                    len_cnt_nxt = len_cnt - LEN_ONE;
                end
            end
            ST_RESET: begin
                if (len_cnt == '0) state_nxt = ST_DONE;
                else               len_cnt_nxt = len_cnt - LEN_ONE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (abort_hit) state_nxt = ST_DONE;
    end

    // Outputs are decoded from the next state and then registered.
    logic       shifting_nxt;
    logic [9:0] res_d;

    assign shifting_nxt = (state_nxt == ST_SHIFT_HI) || (state_nxt == ST_SHIFT_LO);
    assign res_d        = (state_nxt == ST_RESET) ? res_nxt : 10'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_cnt   <= '0;
            phase_cnt <= 8'd0;
            op_q      <= OP_ACQUIRE;
            res_q     <= 10'd0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= 10'd0;
            store     <= 1'b0;
            strobe    <= 1'b0;
            gate      <= 1'b0;
            sh_a      <= 1'b0;
            sh_b      <= 1'b0;
            clk_sh    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state     <= state_nxt;
            len_cnt   <= len_cnt_nxt;
            phase_cnt <= phase_nxt;
            op_q      <= op_nxt;
            res_q     <= res_nxt;
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done      <= (state_nxt == ST_DONE);
            res       <= res_d;
            store     <= (state_nxt == ST_STORE);
            strobe    <= (state_nxt == ST_STROBE);
            gate      <= (state_nxt == ST_GATE);
            sh_a      <= shifting_nxt && (op_nxt == OP_SHIFT_A);
            sh_b      <= shifting_nxt && (op_nxt == OP_SHIFT_B);
            clk_sh    <= (state_nxt == ST_SHIFT_HI);
        end
    end

endmodule

// File: tb/tb_pmc_pm_sequencer.sv
// Self-checking bench for pmc_pm_sequencer: per-cycle output vectors compared against
// waveforms built from the command rules (gate/strobe/store, clk_sh pulses, res pulse).
module tb_pmc_pm_sequencer;

    localparam int CLK_DIV       = 2;
    localparam int STROBE_CYCLES = 2;
    localparam int LEN_W         = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [9:0]       cmd_res = 10'd0;
`ifdef PMC_SEQ_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy, done, store, strobe, gate, sh_a, sh_b, clk_sh;
    logic [9:0]       res;

    pmc_pm_sequencer #(
        .CLK_DIV(CLK_DIV), .STROBE_CYCLES(STROBE_CYCLES), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_res(cmd_res),
`ifdef PMC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .res(res), .store(store), .strobe(strobe),
        .gate(gate), .sh_a(sh_a), .sh_b(sh_b), .clk_sh(clk_sh)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed vector: {cmd_ready, busy, done, res[9:0], store, strobe, gate, sh_a, sh_b, clk_sh}
    logic [18:0] obs;
    assign obs = {cmd_ready, busy, done, res, store, strobe, gate, sh_a, sh_b, clk_sh};

    localparam logic [18:0] IDLE_V   = 19'h40000;
    localparam logic [18:0] B_BUSY   = 19'h20000;
    localparam logic [18:0] DONE_V   = 19'h10000;
    localparam logic [18:0] B_STORE  = 19'h00020;
    localparam logic [18:0] B_STROBE = 19'h00010;
    localparam logic [18:0] B_GATE   = 19'h00008;
    localparam logic [18:0] B_SHA    = 19'h00004;
    localparam logic [18:0] B_SHB    = 19'h00002;
    localparam logic [18:0] B_CLK    = 19'h00001;

    logic [18:0] exp_q[$];

    // Reference waveform for one command starting the cycle after acceptance:
    // busy cycles, then one done cycle, then one idle cycle. cut >= 0 keeps only
    // the first cut busy cycles (command aborted).
    function automatic void model_cmd(int op, int len, logic [9:0] r, int cut);
        logic [18:0] b[$];
        logic [18:0] sh;
        int n;
        n  = (len == 0) ? 1 : len;
        sh = (op == 1) ? B_SHA : B_SHB;
        case (op)
            0: begin
                repeat (n) b.push_back(B_BUSY | B_GATE);
                repeat (STROBE_CYCLES) b.push_back(B_BUSY | B_STROBE);
                b.push_back(B_BUSY | B_STORE);
            end
            1, 2: begin
                for (int p = 0; p < n; p++) begin
                    repeat (CLK_DIV) b.push_back(B_BUSY | sh | B_CLK);
                    repeat (CLK_DIV) b.push_back(B_BUSY | sh);
                end
            end
            default: repeat (n) b.push_back(B_BUSY | 19'({r, 6'b0}));
        endcase
        if (cut >= 0) while (b.size() > cut) void'(b.pop_back());
        foreach (b[i]) exp_q.push_back(b[i]);
        exp_q.push_back(DONE_V);
        exp_q.push_back(IDLE_V);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== IDLE_V) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, obs, IDLE_V);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== IDLE_V) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got %h want %h", i, obs, IDLE_V);
            end
        end
    endtask

    task automatic test_acquire();
        exp_q.delete();
        model_cmd(0, 5, 10'd0, -1);
        cmd_op = 2'd0; cmd_len = LEN_W'(5); cmd_res = 10'd0; cmd_valid = 1'b1;
        foreach (exp_q[i]) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL acquire cycle %0d: got %h want %h", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_shift();
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            model_cmd(2, (k == 0) ? 3 : 0, 10'd0, -1);
            cmd_op = 2'd2; cmd_len = LEN_W'((k == 0) ? 3 : 0); cmd_valid = 1'b1;
            foreach (exp_q[i]) begin
                @(negedge clk);
                if (i == 0) cmd_valid = 1'b0;
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL shift_b len%0d cycle %0d: got %h want %h",
                             (k == 0) ? 3 : 0, i + 1, obs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_cmd();
        exp_q.delete();
        model_cmd(3, 4, 10'h2A5, -1);
        cmd_op = 2'd3; cmd_len = LEN_W'(4); cmd_res = 10'h2A5; cmd_valid = 1'b1;
        foreach (exp_q[i]) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_valid = 1'b0;
                cmd_res   = 10'h15A;
                cmd_len   = LEN_W'(40);
                cmd_op    = 2'd1;
            end
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_cmd cycle %0d: got %h want %h", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_len;
        exp_q.delete();
        model_cmd(0, 3, 10'd0, -1);
        first_len = exp_q.size();
        model_cmd(1, 2, 10'd0, -1);
        cmd_op = 2'd0; cmd_len = LEN_W'(3); cmd_valid = 1'b1;
        foreach (exp_q[i]) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_op  = 2'd1;
                cmd_len = LEN_W'(2);
            end
            if (i == first_len) cmd_valid = 1'b0;
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int op, len, gap;
            logic [9:0] r;
            op  = $urandom_range(0, 3);
            len = $urandom_range(0, 6);
            gap = $urandom_range(0, 2);
            r   = 10'($urandom);
            for (int g = 0; g < gap; g++) begin
                cmd_op = 2'($urandom); cmd_len = LEN_W'($urandom);
                @(negedge clk);
                total++;
                if (obs !== IDLE_V) begin
                    bad++;
                    $display("FAIL random_gap cmd %0d: got %h want %h", n, obs, IDLE_V);
                end
            end
            exp_q.delete();
            model_cmd(op, len, r, -1);
            cmd_op = 2'(op); cmd_len = LEN_W'(len); cmd_res = r; cmd_valid = 1'b1;
            foreach (exp_q[i]) begin
                @(negedge clk);
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("FAIL random cmd %0d op %0d len %0d cycle %0d: got %h want %h",
                             n, op, len, i + 1, obs, exp_q[i]);
                end
                cmd_op    = 2'($urandom);
                cmd_len   = LEN_W'($urandom);
                cmd_res   = 10'($urandom);
                cmd_valid = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        cmd_op = 2'd0; cmd_len = LEN_W'(6); cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            total++;
            if (obs !== (B_BUSY | B_GATE)) begin
                bad++;
                $display("FAIL async_pre cycle %0d: got %h want %h", i + 1, obs, B_BUSY | B_GATE);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== IDLE_V) begin
            bad++;
            $display("FAIL async_assert: got %h want %h", obs, IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (obs !== IDLE_V) begin
                bad++;
                $display("FAIL async_no_done cycle %0d: got %h want %h", i, obs, IDLE_V);
            end
        end
    endtask

`ifdef PMC_SEQ_ABORT_EN
    task automatic test_abort();
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== IDLE_V) begin
                bad++;
                $display("FAIL abort_idle cycle %0d: got %h want %h", i, obs, IDLE_V);
            end
        end
        abort = 1'b0;
        // Abort sampled at the end of cycle 5, the first high cycle of the 2nd clk_sh pulse.
        exp_q.delete();
        model_cmd(1, 8, 10'd0, 5);
        cmd_op = 2'd1; cmd_len = LEN_W'(8); cmd_valid = 1'b1;
        foreach (exp_q[i]) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_shift cycle %0d: got %h want %h", i + 1, obs, exp_q[i]);
            end
            if (i == 4) abort = 1'b1;
            if (i == 6) abort = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_acquire();
        test_shift();
        test_reset_cmd();
        test_back_to_back();
        test_random();
`ifdef PMC_SEQ_ABORT_EN
        test_abort();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
